// File: rtl/pc_unit.sv
// Program counter stage: holds the fetch PC, advances by 4, honours stalls and
// loads redirect targets with a one-cycle bubble. Optional macro: PC_TRAP_EN.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic            jalr,
  input  logic [XLEN-1:0] target_base,
  input  logic [XLEN-1:0] target_offset,
  input  logic            trap_ack,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_valid,
  output logic            misalign,
  output logic [XLEN-1:0] trap_pc,
  output logic [31:0]     fetch_count
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
`ifdef PC_TRAP_EN
    , TRAP
`endif
  } state_t;

  state_t          state, next_state;
  logic [XLEN-1:0] pc_q, next_pc;
  logic            misalign_q, next_misalign;
  logic [31:0]     count_q, next_count;
  logic [XLEN-1:0] tgt_sum, tgt;

  assign tgt_sum = target_base + target_offset;
  assign tgt     = {tgt_sum[XLEN-1:1], tgt_sum[0] & ~jalr};

`ifdef PC_TRAP_EN
  logic [XLEN-1:0] trap_pc_q, next_trap_pc;
  assign trap_pc = trap_pc_q;
`else
  logic unused_trap_ack;
  assign unused_trap_ack = trap_ack;
  assign trap_pc = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
      count_q    <= '0;
`ifdef PC_TRAP_EN
      trap_pc_q  <= '0;
`endif
    end else begin
      state      <= next_state;
      pc_q       <= next_pc;
      misalign_q <= next_misalign;
      count_q    <= next_count;
`ifdef PC_TRAP_EN
      trap_pc_q  <= next_trap_pc;
`endif
    end
  end

  always_comb begin
    next_state    = state;
    next_pc       = pc_q;
    next_misalign = 1'b0;
    next_count    = count_q;
`ifdef PC_TRAP_EN
    next_trap_pc  = trap_pc_q;
`endif
    case (state)
      BOOT:  next_state = RUN;
      RUN: begin
        if (redirect) begin
          if (tgt[1:0] == 2'b00) begin
            next_pc    = tgt;
            next_state = FLUSH;
          end else begin
            next_misalign = 1'b1;
`ifdef PC_TRAP_EN
            next_pc      = TRAP_VECTOR;
            next_trap_pc = tgt;
            next_state   = TRAP;
`else
            next_pc    = {tgt[XLEN-1:2], 2'b00};
            next_state = FLUSH;
`endif
          end
        end else if (!stall) begin
          next_pc    = pc_q + XLEN'(4);
          next_count = count_q + 32'd1;
        end
      end
      FLUSH: next_state = RUN;
`ifdef PC_TRAP_EN
      TRAP:  if (trap_ack) next_state = RUN;
`endif
      default: next_state = BOOT;
    endcase
  end

  assign pc_out      = pc_q;
  assign pc_plus4    = pc_q + XLEN'(4);
  assign pc_valid    = (state == RUN);
  assign misalign    = misalign_q;
  assign fetch_count = count_q;

endmodule
